// File: rtl/glitch_sequencer.sv
// Armed glitch-timing controller driving the glitch clock mux select; trigger-pin to edge takes SYNC_STAGES+1 cycles,
// first glitch_sel at edge+delay+1. No backpressure: config is sampled on arm, arm/trigger outside their states are dropped.
module glitch_sequencer #(
  parameter int CNT_W       = 16,
  parameter int NUM_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in1,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic             arm,
  input  logic             trigger,
  input  logic             abort,
  output logic             glitch_sel,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] glitch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] delay_q, width_q, gap_q;
  logic [NUM_W-1:0] num_q;
  logic             glitch_sel_q, armed_q, busy_q, done_q;
  logic [NUM_W-1:0] glitch_cnt_q;

  logic [CNT_W-1:0] width_eff, gap_eff;
  logic [NUM_W-1:0] num_eff;
  logic [NUM_W-1:0] glitch_cnt_d;

  assign width_eff    = (cfg_width == '0) ? CNT_ONE : cfg_width;
  assign gap_eff      = (cfg_gap == '0) ? CNT_ONE : cfg_gap;
  assign num_eff      = (cfg_num == '0) ? NUM_ONE : cfg_num;
  assign glitch_cnt_d = (glitch_cnt_q == '1) ? glitch_cnt_q : glitch_cnt_q + NUM_ONE;

  // Registered edge pulse keeps the pin-to-edge latency at SYNC_STAGES+1.
  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      delay_q      <= '0;
      width_q      <= '0;
      gap_q        <= '0;
      num_q        <= '0;
      glitch_sel_q <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      glitch_cnt_q <= '0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      glitch_sel_q <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            delay_q      <= cfg_delay;
            width_q      <= width_eff;
            gap_q        <= gap_eff;
            num_q        <= num_eff;
            glitch_cnt_q <= '0;
            armed_q      <= 1'b1;
            state_q      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (edge_q) begin
            armed_q <= 1'b0;
            busy_q  <= 1'b1;
            if (delay_q == '0) begin
              state_q      <= S_GLITCH;
              glitch_sel_q <= 1'b1;
              cnt_q        <= width_q;
            end else begin
              state_q <= S_DELAY;
              cnt_q   <= delay_q;
            end
          end
        end
        S_DELAY, S_GAP: begin
          if (cnt_q == CNT_ONE) begin
            state_q      <= S_GLITCH;
            glitch_sel_q <= 1'b1;
            cnt_q        <= width_q;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_GLITCH: begin
          if (cnt_q == CNT_ONE) begin
            glitch_sel_q <= 1'b0;
            glitch_cnt_q <= glitch_cnt_d;
            if (glitch_cnt_d >= num_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= gap_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign glitch_sel = glitch_sel_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed sequences push expected select edges and done pulses into a queue,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_glitch_sequencer;
  localparam int CNT_W = 16;
  localparam int NUM_W = 4;
  localparam int SYNC  = 2;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  logic             clk_in1 = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] cfg_delay = '0, cfg_width = '0, cfg_gap = '0;
  logic [NUM_W-1:0] cfg_num = '0;
  logic             arm = 1'b0, trigger = 1'b0, abort = 1'b0;
  logic             glitch_sel, armed, busy, done;
  logic [NUM_W-1:0] glitch_cnt;

  glitch_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W), .SYNC_STAGES(SYNC)) dut (
    .clk_in1(clk_in1), .rst(rst),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_num(cfg_num),
    .arm(arm), .trigger(trigger), .abort(abort),
    .glitch_sel(glitch_sel), .armed(armed), .busy(busy), .done(done), .glitch_cnt(glitch_cnt)
  );

  always #5 clk_in1 = ~clk_in1;

  int cyc = 0;
  always @(posedge clk_in1) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;
  ev_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic sel_prev = 1'b0;

  task automatic push(input int k, input int c, input int n);
    ev_t e;
    e.kind = k; e.cyc = c; e.cnt = n;
    exp_q.push_back(e);
  endtask

  // Expected events for a full sequence whose edge lands in cycle e.
  task automatic push_seq(input int e, input int d, input int w, input int g, input int n);
    int we, ge, ne, t;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    ne = (n == 0) ? 1 : n;
    t  = e + d + 1;
    for (int i = 0; i < ne; i++) begin
      push(K_RISE, t, 0);
      push(K_FALL, t + we, 0);
      if (i == ne - 1) push(K_DONE, t + we, ne);
      t = t + we + ge;
    end
  endtask

  task automatic report(input int k, input int n);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d cnt=%0d at cycle %0d, expected no event", k, n, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.cnt != n) begin
        errors++;
        $display("FAIL event: got kind=%0d cycle=%0d cnt=%0d, expected kind=%0d cycle=%0d cnt=%0d",
                 k, cyc, n, e.kind, e.cyc, e.cnt);
      end
    end
  endtask

  always @(negedge clk_in1) begin
    if (glitch_sel !== sel_prev) begin
      report((glitch_sel === 1'b1) ? K_RISE : K_FALL, 0);
      sel_prev = glitch_sel;
    end
    if (done === 1'b1) report(K_DONE, int'(glitch_cnt));
  end

  task automatic step();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Program config, pulse arm, raise trigger; returns the cycle the edge reaches the FSM.
  task automatic run_seq(input int d, input int w, input int g, input int n, output int e);
    cfg_delay = CNT_W'(d);
    cfg_width = CNT_W'(w);
    cfg_gap   = CNT_W'(g);
    cfg_num   = NUM_W'(n);
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    trigger = 1'b1;
    e = cyc + SYNC + 1;
  endtask

  task automatic finish_seq(input string name, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d events outstanding after %0d cycles, expected 0", name, exp_q.size(), maxc);
      exp_q.delete();
    end
    trigger = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (3) step();
    chk("rst_glitch_sel", glitch_sel, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_glitch_cnt", glitch_cnt, 0);
    rst = 1'b1;
    repeat (2) step();

    // Trigger edge while IDLE: nothing may happen.
    trigger = 1'b1;
    repeat (8) step();
    chk("unarmed_glitch_sel", glitch_sel, 0);
    chk("unarmed_busy", busy, 0);
    chk("unarmed_armed", armed, 0);
    trigger = 1'b0;
    repeat (4) step();

    // Basic: delay 5, width 3, gap 4, two glitches.
    run_seq(5, 3, 4, 2, e);
    push(K_RISE, e + 6, 0); push(K_FALL, e + 9, 0);
    push(K_RISE, e + 13, 0); push(K_FALL, e + 16, 0); push(K_DONE, e + 16, 2);
    finish_seq("basic", 60);
    chk("basic_glitch_cnt", glitch_cnt, 2);
    chk("basic_busy", busy, 0);

    run_seq(0, 0, 0, 0, e);
    push_seq(e, 0, 0, 0, 0);
    finish_seq("zero", 30);
    chk("zero_glitch_cnt", glitch_cnt, 1);

    // Width changed after arming must not affect the window.
    run_seq(2, 3, 1, 1, e);
    cfg_width = CNT_W'(9);
    push_seq(e, 2, 3, 1, 1);
    finish_seq("latch", 40);

    // Abort in the second cycle of glitch 2 of 3.
    run_seq(1, 3, 2, 3, e);
    push(K_RISE, e + 2, 0); push(K_FALL, e + 5, 0);
    push(K_RISE, e + 7, 0); push(K_FALL, e + 9, 0);
    while (cyc < e + 8) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_glitch_sel", glitch_sel, 0);
    chk("abort_busy", busy, 0);
    chk("abort_armed", armed, 0);
    chk("abort_glitch_cnt", glitch_cnt, 1);
    finish_seq("abort", 30);

    // Asynchronous reset mid-glitch.
    run_seq(2, 4, 1, 2, e);
    push(K_RISE, e + 3, 0); push(K_FALL, e + 4, 0);
    while (cyc < e + 4) step();
    chk("pre_rst_glitch_sel", glitch_sel, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_glitch_sel", glitch_sel, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_armed", armed, 0);
    chk("async_rst_glitch_cnt", glitch_cnt, 0);
    trigger = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    finish_seq("async_rst", 20);

    run_seq(5, 3, 4, 2, e);
    push(K_RISE, e + 6, 0); push(K_FALL, e + 9, 0);
    push(K_RISE, e + 13, 0); push(K_FALL, e + 16, 0); push(K_DONE, e + 16, 2);
    finish_seq("rearm", 60);
    chk("rearm_glitch_cnt", glitch_cnt, 2);

    // Second trigger edge and arm pulse during GAP must be ignored.
    run_seq(1, 2, 5, 2, e);
    push_seq(e, 1, 2, 5, 2);
    while (cyc < e + 4) step();
    trigger = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    trigger = 1'b1;
    finish_seq("ignored", 40);
    chk("ignored_armed", armed, 0);
    chk("ignored_glitch_cnt", glitch_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
